// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the CPU's single memory port with a DMA requester.
// Fixed CPU priority; a starvation counter forces a DMA grant after STARVE_MAX
// consecutive CPU grants while DMA is waiting. Req/ack handshake on both sides.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OWN_IDLE   = 2'b00;
  localparam logic [1:0] OWN_CPU    = 2'b01;
  localparam logic [1:0] OWN_DMA    = 2'b10;
  localparam logic [1:0] WAIT_INIT  = 2'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic       win_dma;     // latched winner: 1 = DMA, 0 = CPU
  logic       win_we;      // latched direction of the transaction in flight
  logic [1:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       dma_win;

  // DMA takes the port when the CPU is silent or the CPU has starved it long enough
  always_comb begin
    dma_win = 1'b0;
    if (dma_req && (!cpu_req || (starve_cnt == STARVE_LIM))) begin
      dma_win = 1'b1;
    end
  end

  // Transaction FSM: grant in IDLE, one-cycle strobe in ISSUE, latency in WAIT, ack in DONE.
  // Reads always pass through WAIT for MEM_LAT cycles (wait_cnt starts at MEM_LAT-1), so
  // mem_rdata is sampled MEM_LAT cycles after the issue cycle and read ack lands in cycle
  // MEM_LAT+2 for every legal MEM_LAT, including 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      win_dma    <= 1'b0;
      win_we     <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= OWN_IDLE;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_win) begin
            win_dma    <= 1'b1;
            win_we     <= dma_we;
            mem_addr   <= dma_addr;
            mem_wdata  <= dma_wdata;
            mem_read   <= !dma_we;
            mem_write  <= dma_we;
            owner      <= OWN_DMA;
            starve_cnt <= '0;
            state      <= ISSUE;
          end else if (cpu_req) begin
            win_dma   <= 1'b0;
            win_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_read  <= !cpu_we;
            mem_write <= cpu_we;
            owner     <= OWN_CPU;
            if (!dma_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            state <= ISSUE;
          end else begin
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          if (win_we) begin
            cpu_ack <= !win_dma;
            dma_ack <= win_dma;
            state   <= DONE;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (win_dma) begin
              dma_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= mem_rdata;
            end
            cpu_ack <= !win_dma;
            dma_ack <= win_dma;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        DONE: begin
          owner <= OWN_IDLE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share one stimulus set:
// index 0 = MEM_LAT 1 / STARVE_MAX 8, 1 = MEM_LAT 2 / STARVE_MAX 2, 2 = MEM_LAT 3 / STARVE_MAX 8.
// Each instance has its own latency-pipelined memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic [31:0] cpu_rdata [3];
  logic [31:0] dma_rdata [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic        cpu_ack   [3];
  logic        dma_ack   [3];
  logic        mem_read  [3];
  logic        mem_write [3];
  logic [1:0]  owner     [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] exp_own [$];
  int         exp_gap [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0040: return 32'h1234_5678;
      default:       return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen
    localparam int LAT  = g + 1;
    localparam int SMAX = (g == 1) ? 2 : 8;
    logic [31:0] pipe [LAT];

    mem_port_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .MEM_LAT   (LAT),
      .STARVE_MAX(SMAX)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata[g]),
      .cpu_ack  (cpu_ack[g]),
      .dma_req  (dma_req),
      .dma_we   (dma_we),
      .dma_addr (dma_addr),
      .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata[g]),
      .dma_ack  (dma_ack[g]),
      .mem_read (mem_read[g]),
      .mem_write(mem_write[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .owner    (owner[g])
    );

    // Memory: read strobed in cycle t yields data in cycle t+LAT
    always @(posedge clk) begin
      if (mem_read[g]) pipe[0] <= mem_model(mem_addr[g]);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Follow instance g for n grants: check owner order, grant spacing, no cross ack
  task automatic watch_grants(input int g, input int n, input string name);
    int seen = 0;
    int last = 0;
    logic [1:0] prev = 2'b00;
    for (int c = 0; c < 200 && seen < n; c++) begin
      tick();
      if (owner[g] == 2'b01)
        check($sformatf("%s_xack_c%0d", name, c), {31'b0, dma_ack[g]}, 32'd0);
      else if (owner[g] == 2'b10)
        check($sformatf("%s_xack_c%0d", name, c), {31'b0, cpu_ack[g]}, 32'd0);
      if (prev == 2'b00 && owner[g] != 2'b00) begin
        check($sformatf("%s_own%0d", name, seen), {30'b0, owner[g]}, {30'b0, exp_own[seen]});
        if (seen > 0)
          check($sformatf("%s_gap%0d", name, seen), c - last, exp_gap[seen]);
        last = c;
        seen++;
      end
      prev = owner[g];
    end
    check($sformatf("%s_grants", name), seen, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state of all instances
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_owner_g%0d", g), {30'b0, owner[g]}, 32'd0);
      check($sformatf("rst_strobes_g%0d", g), {30'b0, mem_read[g], mem_write[g]}, 32'd0);
      check($sformatf("rst_acks_g%0d", g), {30'b0, cpu_ack[g], dma_ack[g]}, 32'd0);
      check($sformatf("rst_cpu_rdata_g%0d", g), cpu_rdata[g], 32'd0);
      check($sformatf("rst_dma_rdata_g%0d", g), dma_rdata[g], 32'd0);
      check($sformatf("rst_mem_addr_g%0d", g), mem_addr[g], 32'd0);
    end

    // Reset mid-read on the MEM_LAT=3 instance
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midrst_owner", {30'b0, owner[2]}, 32'd0);
    check("midrst_strobes", {30'b0, mem_read[2], mem_write[2]}, 32'd0);
    check("midrst_ack", {31'b0, cpu_ack[2]}, 32'd0);
    check("midrst_rdata", cpu_rdata[2], 32'd0);
    tick();
    check("midrst_ack_held", {31'b0, cpu_ack[2]}, 32'd0);
    reset = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        check($sformatf("rd100_ack_g%0d_c%0d", g, c), {31'b0, cpu_ack[g]},
              (c == g + 3) ? 32'd1 : 32'd0);
        if (c == g + 3)
          check($sformatf("rd100_rdata_g%0d", g), cpu_rdata[g], 32'hDEAD_BEEF);
      end
    end

    // Single CPU read, MEM_LAT=2 instance
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("rd40_mem_read_c%0d", c), {31'b0, mem_read[1]}, (c == 1) ? 32'd1 : 32'd0);
      check($sformatf("rd40_ack_c%0d", c), {31'b0, cpu_ack[1]}, (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("rd40_dma_ack_c%0d", c), {31'b0, dma_ack[1]}, 32'd0);
      check($sformatf("rd40_owner_c%0d", c), {30'b0, owner[1]}, (c <= 4) ? 32'd1 : 32'd0);
      if (c == 1) check("rd40_mem_addr", mem_addr[1], 32'h40);
      if (c == 4) check("rd40_rdata", cpu_rdata[1], 32'h1234_5678);
    end

    // Single DMA write with CPU idle: immediate grant
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'hA5A5_A5A5;
    for (int c = 1; c <= 3; c++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        check($sformatf("dw_mem_write_g%0d_c%0d", g, c), {31'b0, mem_write[g]}, (c == 1) ? 32'd1 : 32'd0);
        check($sformatf("dw_mem_read_g%0d_c%0d", g, c), {31'b0, mem_read[g]}, 32'd0);
        check($sformatf("dw_dma_ack_g%0d_c%0d", g, c), {31'b0, dma_ack[g]}, (c == 2) ? 32'd1 : 32'd0);
        check($sformatf("dw_cpu_ack_g%0d_c%0d", g, c), {31'b0, cpu_ack[g]}, 32'd0);
        check($sformatf("dw_owner_g%0d_c%0d", g, c), {30'b0, owner[g]}, (c <= 2) ? 32'd2 : 32'd0);
        check($sformatf("dw_mem_addr_g%0d_c%0d", g, c), mem_addr[g], 32'h80);
        if (c == 1) check($sformatf("dw_mem_wdata_g%0d", g), mem_wdata[g], 32'hA5A5_A5A5);
      end
    end

    // Starvation guard, STARVE_MAX=2: continuous CPU reads vs continuous DMA writes
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h5555_5555;
    exp_own = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    exp_gap = '{0, 5, 5, 3, 5, 5};
    watch_grants(1, 6, "starve2");

    // Back-to-back writes from both sides, MEM_LAT=1, STARVE_MAX=8
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h2222_2222;
    exp_own = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    exp_gap = '{0, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    watch_grants(0, 10, "b2bwr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
